// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides and NZCV flags.
// Single-cycle ops complete in IDLE; MUL runs an iterative shift-add sequence.
module alu_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_OR  = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic [SW-1:0]      sh;
  logic [WIDTH:0]     sum, diff, shl_x, shr_x;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_res;
  logic               wr_c, wr_v;

  assign in_ready  = !reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out       = res_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign sh        = in2[SW-1:0];

  // Shifts run one bit wider so the extra bit holds the last bit shifted out
  // (and is naturally 0 for a zero shift amount).
  always_comb begin
    sum     = {1'b0, in1} + {1'b0, in2};
    diff    = {1'b0, in1} - {1'b0, in2};
    shl_x   = {1'b0, in1} << sh;
    shr_x   = {in1, 1'b0} >> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_AND: alu_res = in1 & in2;
      OP_XOR: alu_res = in1 ^ in2;
      OP_OR:  alu_res = in1 | in2;
      OP_SHL: begin
        alu_res = shl_x[WIDTH-1:0];
        alu_c   = shl_x[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_x[WIDTH:1];
        alu_c   = shr_x[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_res      = '0;
    wr_c        = 1'b0;
    wr_v        = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if ((op == OP_MUL) && MUL_EN) begin
            state_d = S_MUL;
            a_d     = {{WIDTH{1'b0}}, in1};
            b_d     = in2;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            wr_en  = 1'b1;
            wr_res = alu_res;
            wr_c   = alu_c;
            wr_v   = alu_v;
          end
        end
      end
      S_MUL: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        wr_en   = 1'b1;
        wr_res  = acc_q[WIDTH-1:0];
        wr_c    = |acc_q[2*WIDTH-1:WIDTH];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) begin
      res_d       = wr_res;
      zero_d      = (wr_res == '0);
      neg_d       = wr_res[WIDTH-1];
      carry_d     = wr_c;
      ovf_d       = wr_v;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, handshake corner
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_pipe;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] out;
    logic         z, n, c, v;
  } res_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    res_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in1, in2;
  logic [2:0]   op;
  logic         out_valid, out_ready;
  logic [W-1:0] out;
  logic         zero, neg, carry, ovf, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .zero      (zero),
    .neg       (neg),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the op definitions.
  function automatic res_t model(input logic [2:0] o, input int unsigned a, input int unsigned b);
    res_t r;
    int unsigned full = 1 << W;
    int unsigned half = 1 << (W - 1);
    int unsigned v;
    int unsigned amt = b % W;
    longint unsigned p;
    int sa, sb, s;
    sa = (a >= half) ? int'(a) - int'(full) : int'(a);
    sb = (b >= half) ? int'(b) - int'(full) : int'(b);
    r.c = 1'b0;
    r.v = 1'b0;
    case (o)
      3'd0: begin
        v = a + b;
        r.c = (v >= full);
        s = sa + sb;
        r.v = (s > int'(half) - 1) || (s < -int'(half));
      end
      3'd1: begin
        v = (a + full - b) % full;
        r.c = (a < b);
        s = sa - sb;
        r.v = (s > int'(half) - 1) || (s < -int'(half));
      end
      3'd2: v = a & b;
      3'd3: v = a ^ b;
      3'd4: v = a | b;
      3'd5: begin
        v = (a << amt) % full;
        r.c = (amt != 0) && (((a >> (W - amt)) & 1) == 1);
      end
      3'd6: begin
        v = a >> amt;
        r.c = (amt != 0) && (((a >> (amt - 1)) & 1) == 1);
      end
      default: begin
        p = longint'(a) * longint'(b);
        v = int'(p % full);
        r.c = (p / full) != 0;
      end
    endcase
    r.out = v[W-1:0];
    r.z   = (v % full) == 0;
    r.n   = (v % full) >= half;
    return r;
  endfunction

  function automatic logic [31:0] pack(input logic ov, input res_t r);
    return {19'd0, ov, r.out, r.z, r.n, r.c, r.v};
  endfunction

  function automatic logic [31:0] dut_bits();
    return {19'd0, out_valid, out, zero, neg, carry, ovf};
  endfunction

  // Issue one op with out_ready low, check latency, result, hold stability,
  // then drain. Garbage with in_valid=1 is driven while the block is not ready.
  task automatic run_op(input logic [2:0] op_v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input res_t exp, input int unsigned hold, input string tag);
    int unsigned wait_n, lat, bad, unstable, exp_lat;
    @(negedge clk);
    wait_n = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk({tag, " in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    op = op_v;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    op  = 3'($urandom);
    in1 = W'($urandom);
    in2 = W'($urandom);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    exp_lat = (op_v == 3'b111) ? W + 1 : 0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_gate"}, bad, 0);
    chk({tag, " result"}, dut_bits(), pack(1'b1, exp));
    unstable = 0;
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (dut_bits() !== pack(1'b1, exp) || in_ready) unstable++;
    end
    if (hold != 0) chk({tag, " hold"}, unstable, 0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, " drained"}, out_valid, 0);
  endtask

  vec_t vecs[17];

  initial begin
    res_t e;
    int unsigned quiet;

    vecs[0]  = '{3'd0, 8'd200, 8'd100, '{8'd44,  1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{3'd1, 8'd5,   8'd5,   '{8'd0,   1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{3'd1, 8'd3,   8'd5,   '{8'd254, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[3]  = '{3'd0, 8'd127, 8'd1,   '{8'd128, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[4]  = '{3'd7, 8'd13,  8'd11,  '{8'd143, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[5]  = '{3'd7, 8'd20,  8'd20,  '{8'd144, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[6]  = '{3'd5, 8'h81,  8'd1,   '{8'h02,  1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[7]  = '{3'd6, 8'h81,  8'd3,   '{8'h10,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{3'd4, 8'hF0,  8'h0F,  '{8'hFF,  1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{3'd2, 8'hF0,  8'h3C,  '{8'h30,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{3'd3, 8'hAA,  8'hFF,  '{8'h55,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{3'd1, 8'h80,  8'h01,  '{8'h7F,  1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[12] = '{3'd5, 8'h81,  8'h08,  '{8'h81,  1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[13] = '{3'd0, 8'hFF,  8'h01,  '{8'h00,  1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[14] = '{3'd7, 8'hFF,  8'hFF,  '{8'h01,  1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[15] = '{3'd7, 8'h00,  8'd77,  '{8'h00,  1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[16] = '{3'd6, 8'hC0,  8'd7,   '{8'h01,  1'b0, 1'b0, 1'b1, 1'b0}};

    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in1 = '0;
    in2 = '0;
    op = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", dut_bits(), 32'd0);
    chk("reset busy", busy, 0);
    chk("reset in_ready", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", in_ready, 1);

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, i % 3, $sformatf("vec%0d", i));

    // Backpressure for 5 cycles, then consume and issue on the same edge.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; in1 = 8'd10; in2 = 8'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    e = '{8'd30, 1'b0, 1'b0, 1'b0, 1'b0};
    chk("bp first", dut_bits(), pack(1'b1, e));
    quiet = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (dut_bits() !== pack(1'b1, e) || in_ready) quiet++;
    end
    chk("bp stable", quiet, 0);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; op = 3'd3; in1 = 8'h0F; in2 = 8'hFF;
    #1;
    chk("bp in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp second", dut_bits(), pack(1'b1, '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    chk("bp drain", out_valid, 0);
    out_ready = 1'b0;

    // Reset during the 4th MUL cycle aborts without a result.
    @(negedge clk);
    in_valid = 1'b1; op = 3'd7; in1 = 8'd13; in2 = 8'd11;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("mul busy before reset", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", busy, 0);
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort in_ready after", in_ready, 1);
    quiet = 0;
    for (int unsigned i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) quiet++;
    end
    chk("abort no result", quiet, 0);
    run_op(3'd0, 8'd1, 8'd1, '{8'd2, 1'b0, 1'b0, 1'b0, 1'b0}, 0, "after abort");

    for (int unsigned i = 0; i < 300; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ro, ra, rb, model(ro, ra, rb), $urandom_range(0, 3), $sformatf("rnd%0d op%0d", i, ro));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
